ser_tx_param: RTL and testbench

Parametrised transmit serializer for the SerDes TX path. It accepts parallel words (default 10 bits, 8b/10b encoded) over a valid/ready handshake into a one-entry holding register and shifts them out one bit per enabled clock. Bit order is selectable. When no word is available at a word boundary, the block inserts a configurable idle/comma word and flags underflow. It sits between the 8b/10b encoder and the TX driver.

---
 rtl/ser_tx_param.sv | 93 +++++++++
 tb/tb_ser_tx_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx_param.sv
// Transmit serializer: one-entry holding register feeding a shift register that
// emits one bit per enabled clock, substituting IDLE_WORD when starved.
module ser_tx_param #(
  parameter int               WIDTH     = 10,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'h0FA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             word_start,
  output logic             underflow
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic             sout_r;
  logic             word_start_r;
  logic             underflow_r;

  logic [CW-1:0]    idx_s;
  logic             boundary_s;
  logic             accept_s;

  function automatic logic [CW-1:0] bit_idx(input logic [CW-1:0] c);
    logic [CW-1:0] idx;
    if (LSB_FIRST) begin
      idx = c;
    end else begin
      idx = CNT_LAST - c;
    end
    return idx;
  endfunction

  always_comb begin
    idx_s      = bit_idx(cnt_r);
    boundary_s = en && (cnt_r == CNT_LAST);
    accept_s   = din_valid && !hold_full_r;
  end

  // Bit emission, word counter and reload of the active word at each boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r      <= IDLE_WORD;
      cnt_r        <= CNT_ZERO;
      sout_r       <= 1'b0;
      word_start_r <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      word_start_r <= en && (cnt_r == CNT_ZERO);
      underflow_r  <= boundary_s && !hold_full_r;
      if (en) begin
        sout_r <= shreg_r[idx_s];
        if (boundary_s) begin
          cnt_r   <= CNT_ZERO;
          shreg_r <= hold_full_r ? hold_r : IDLE_WORD;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end
  end

  // Holding register: filled by the handshake, emptied when the boundary consumes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_r      <= din;
      hold_full_r <= 1'b1;
    end else if (boundary_s && hold_full_r) begin
      hold_full_r <= 1'b0;
    end
  end

  assign din_ready  = !hold_full_r;
  assign sout       = sout_r;
  assign word_start = word_start_r;
  assign underflow  = underflow_r;

endmodule

// File: tb/tb_ser_tx_param.sv
// Scoreboard bench for ser_tx_param: a word-level model pushes expected serial
// bits into per-instance queues; a negedge monitor pops and compares them.
module tb_ser_tx_param;

  localparam int QN = 64;

  logic       clk = 1'b0;
  logic       rst0, rst1, en0, en1, dv0, dv1;
  logic [9:0] din0;
  logic [7:0] din1;
  logic       rdy0, rdy1, sout0, sout1, ws0, ws1, uf0, uf1;

  int checks = 0;
  int failures = 0;

  // model state (written only by the model process)
  bit          mfull[2];
  logic [31:0] mhold[2];
  int          nedge[2];
  bit          last_acc[2];
  bit          exp_emit[2], exp_uf[2], exp_rdy[2];
  bit          bq_b[2][QN];
  bit          bq_ws[2][QN];
  int          bq_wr[2];
  int          flush_to[2];
  // monitor state
  int          bq_rd[2];
  bit          exp_sout[2];
  // driver state
  logic [31:0] src[2][16];
  int          src_rd[2], src_wr[2];

  always #5 clk = ~clk;

  ser_tx_param #(.WIDTH(10), .LSB_FIRST(1'b1), .IDLE_WORD(10'h0FA)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .din(din0), .din_valid(dv0),
    .din_ready(rdy0), .sout(sout0), .word_start(ws0), .underflow(uf0)
  );

  ser_tx_param #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_WORD(8'hBC)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .din(din1), .din_valid(dv1),
    .din_ready(rdy1), .sout(sout1), .word_start(ws1), .underflow(uf1)
  );

  function automatic int wid(int i);
    return (i == 0) ? 10 : 8;
  endfunction

  function automatic logic [31:0] idlew(int i);
    return (i == 0) ? 32'h0000_00FA : 32'h0000_00BC;
  endfunction

  function automatic bit lsbf(int i);
    return (i == 0);
  endfunction

  task automatic push_word(int i, logic [31:0] w);
    for (int k = 0; k < wid(i); k++) begin
      bq_b[i][bq_wr[i] % QN]  = lsbf(i) ? w[k] : w[wid(i) - 1 - k];
      bq_ws[i][bq_wr[i] % QN] = (k == 0);
      bq_wr[i]++;
    end
  endtask

  // Word-level reference: every WIDTH-th enabled edge the next word is the held one or IDLE
  task automatic model_step(int i);
    logic r, e, v;
    logic [31:0] d;
    bit acc;
    if (i == 0) begin r = rst0; e = en0; v = dv0; d = {22'h0, din0}; end
    else        begin r = rst1; e = en1; v = dv1; d = {24'h0, din1}; end
    if (!r) begin
      mfull[i] = 1'b0; nedge[i] = 0; last_acc[i] = 1'b0;
      exp_emit[i] = 1'b0; exp_uf[i] = 1'b0; exp_rdy[i] = 1'b1;
      flush_to[i] = bq_wr[i];
      push_word(i, idlew(i));
    end else begin
      acc = v && !mfull[i];
      exp_emit[i] = e;
      exp_uf[i] = 1'b0;
      if (e) begin
        if (nedge[i] % wid(i) == wid(i) - 1) begin
          if (mfull[i]) begin
            push_word(i, mhold[i]);
            mfull[i] = 1'b0;
          end else begin
            push_word(i, idlew(i));
            exp_uf[i] = 1'b1;
          end
        end
        nedge[i]++;
      end
      if (acc) begin
        mhold[i] = d;
        mfull[i] = 1'b1;
      end
      last_acc[i] = acc;
      exp_rdy[i] = !mfull[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  task automatic chk(string nm, int i, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d at %0t: got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  task automatic mon(int i);
    logic r, so, w, u, rd;
    bit ews, eu, er;
    if (i == 0) begin r = rst0; so = sout0; w = ws0; u = uf0; rd = rdy0; end
    else        begin r = rst1; so = sout1; w = ws1; u = uf1; rd = rdy1; end
    if (bq_rd[i] < flush_to[i]) bq_rd[i] = flush_to[i];
    ews = 1'b0;
    if (!r) begin
      exp_sout[i] = 1'b0; eu = 1'b0; er = 1'b1;
    end else begin
      if (exp_emit[i]) begin
        if (bq_rd[i] == bq_wr[i]) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty inst%0d at %0t: got a bit, expected none queued", i, $time);
        end else begin
          exp_sout[i] = bq_b[i][bq_rd[i] % QN];
          ews = bq_ws[i][bq_rd[i] % QN];
          bq_rd[i]++;
        end
      end
      eu = exp_uf[i];
      er = exp_rdy[i];
    end
    chk("sout", i, so, exp_sout[i]);
    chk("word_start", i, w, ews);
    chk("underflow", i, u, eu);
    chk("din_ready", i, rd, er);
  endtask

  initial forever begin
    @(negedge clk);
    mon(0);
    mon(1);
  end

  task automatic drive(int i, logic e, logic v, logic [31:0] d);
    if (i == 0) begin en0 = e; dv0 = v; din0 = d[9:0]; end
    else        begin en1 = e; dv1 = v; din1 = d[7:0]; end
  endtask

  task automatic set_rst(int i, logic r);
    if (i == 0) rst0 = r;
    else        rst1 = r;
  endtask

  task automatic push_src(int i, logic [31:0] w);
    src[i][src_wr[i] % 16] = w;
    src_wr[i]++;
  endtask

  // enmode: 0 = always, 1 = every third cycle, 2 = random; vprob = % chance of offering data
  task automatic run(int i, int n, int enmode, int vprob);
    for (int c = 0; c < n; c++) begin
      logic e, v;
      logic [31:0] d;
      @(posedge clk); #1;
      if (last_acc[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
      case (enmode)
        0:       e = 1'b1;
        1:       e = (c % 3 == 2);
        default: e = ($urandom_range(0, 99) < 75);
      endcase
      d = $urandom;
      v = 1'b0;
      if (src_rd[i] != src_wr[i] && $urandom_range(0, 99) < vprob) begin
        v = 1'b1;
        d = src[i][src_rd[i] % 16];
      end
      drive(i, e, v, d);
    end
  endtask

  task automatic rst_pulse(int i, int n);
    set_rst(i, 1'b0);
    drive(i, 1'b0, 1'b0, 32'h0);
    src_rd[i] = src_wr[i];
    repeat (n) @(posedge clk);
    #1;
    set_rst(i, 1'b1);
    drive(i, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    #1;
    set_rst(1, 1'b0);
    rst_pulse(0, 3);
    // LSB-first, WIDTH=10
    run(0, 10, 0, 0);
    push_src(0, 32'h3A5); push_src(0, 32'h15A);
    run(0, 40, 0, 100);
    push_src(0, 32'h3A5); push_src(0, 32'h2C3);
    run(0, 40, 0, 100);
    push_src(0, $urandom);
    run(0, 50, 0, 100);
    push_src(0, 32'h3A5);
    run(0, 60, 1, 100);
    repeat (40) begin
      if (src_rd[0] == src_wr[0]) push_src(0, $urandom);
      run(0, 10, 2, 70);
    end
    rst_pulse(0, 2);
    push_src(0, $urandom);
    run(0, 30, 0, 100);
    drive(0, 1'b0, 1'b0, 32'h0);
    // MSB-first, WIDTH=8: reset lands four bits into 8'hA5
    rst_pulse(1, 3);
    push_src(1, 32'hA5);
    run(1, 12, 0, 100);
    rst_pulse(1, 2);
    run(1, 30, 0, 0);
    repeat (40) begin
      if (src_rd[1] == src_wr[1]) push_src(1, $urandom);
      run(1, 10, 2, 70);
    end
    drive(1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog at %0t: got no end of stimulus, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
